// File: rtl/udp_port_filter_64.sv
// rtl/udp_port_filter_64.sv - UDP RX port filter: forwards listen-port frames, drops the rest
// Optional frame counters enabled by defining UDP_PORT_FILTER_STATS_EN.
module udp_port_filter_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cfg_port,
    input  logic        s_udp_hdr_valid,
    output logic        s_udp_hdr_ready,
    input  logic [31:0] s_udp_ip_source_ip,
    input  logic [15:0] s_udp_source_port,
    input  logic [15:0] s_udp_dest_port,
    input  logic [15:0] s_udp_length,
    input  logic [63:0] s_udp_payload_axis_tdata,
    input  logic [7:0]  s_udp_payload_axis_tkeep,
    input  logic        s_udp_payload_axis_tvalid,
    output logic        s_udp_payload_axis_tready,
    input  logic        s_udp_payload_axis_tlast,
    input  logic        s_udp_payload_axis_tuser,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [31:0] m_udp_ip_source_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [63:0] m_udp_payload_axis_tdata,
    output logic [7:0]  m_udp_payload_axis_tkeep,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser,
    output logic        busy,
    output logic [31:0] stat_fwd_count,
    output logic [31:0] stat_drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic hdr_match;
    logic hdr_accept;
    logic beat_accept;
    logic fwd_load;

    assign hdr_match   = (s_udp_dest_port == cfg_port) && (s_udp_length >= 16'd8);
    assign hdr_accept  = s_udp_hdr_valid && s_udp_hdr_ready;
    assign beat_accept = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    assign fwd_load    = beat_accept && (state == ST_FORWARD);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        s_udp_hdr_ready           = 1'b0;
        s_udp_payload_axis_tready = 1'b0;
        state_next                = state;
        case (state)
            ST_IDLE: begin
                // A pending output header blocks the next frame until it is consumed
                s_udp_hdr_ready = !m_udp_hdr_valid;
                if (s_udp_hdr_valid && !m_udp_hdr_valid) begin
                    state_next = hdr_match ? ST_FORWARD : ST_DROP;
                end
            end
            ST_FORWARD: begin
                s_udp_payload_axis_tready = !m_udp_payload_axis_tvalid || m_udp_payload_axis_tready;
                if (beat_accept && s_udp_payload_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_udp_payload_axis_tready = 1'b1;
                if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= ST_IDLE;
            m_udp_hdr_valid           <= 1'b0;
            m_udp_payload_axis_tvalid <= 1'b0;
        end else begin
            state <= state_next;
            if (hdr_accept && hdr_match) begin
                m_udp_hdr_valid <= 1'b1;
            end else if (m_udp_hdr_ready) begin
                m_udp_hdr_valid <= 1'b0;
            end
            if (fwd_load) begin
                m_udp_payload_axis_tvalid <= 1'b1;
            end else if (m_udp_payload_axis_tready) begin
                m_udp_payload_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_accept && hdr_match) begin
            m_udp_ip_source_ip <= s_udp_ip_source_ip;
            m_udp_source_port  <= s_udp_source_port;
            m_udp_dest_port    <= s_udp_dest_port;
            m_udp_length       <= s_udp_length;
        end
        if (fwd_load) begin
            m_udp_payload_axis_tdata <= s_udp_payload_axis_tdata;
            m_udp_payload_axis_tkeep <= s_udp_payload_axis_tkeep;
            m_udp_payload_axis_tlast <= s_udp_payload_axis_tlast;
            m_udp_payload_axis_tuser <= s_udp_payload_axis_tuser;
        end
    end

`ifdef UDP_PORT_FILTER_STATS_EN
    logic [31:0] fwd_count_q;
    logic [31:0] drop_count_q;

    // Saturating counters: a wrapped count would look like a quiet link
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_count_q  <= 32'd0;
            drop_count_q <= 32'd0;
        end else begin
            if (hdr_accept && hdr_match && (fwd_count_q != 32'hFFFF_FFFF)) begin
                fwd_count_q <= fwd_count_q + 32'd1;
            end
            if (hdr_accept && !hdr_match && (drop_count_q != 32'hFFFF_FFFF)) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign stat_fwd_count  = fwd_count_q;
    assign stat_drop_count = drop_count_q;
`else
    assign stat_fwd_count  = 32'd0;
    assign stat_drop_count = 32'd0;
`endif

endmodule
